// File: rtl/mem_access_if.sv
// Data SRAM bus between the memory stage (master) and the data memory (slave).
// Request phase handshakes on data_addr_ok; the response arrives later with data_data_ok.
interface mem_access_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic [DATA_W-1:0] data_rdata;
  logic              data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_rdata, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_rdata, data_data_ok
  );
endinterface

// File: rtl/mem_access.sv
// MIPS memory stage: registers execute outputs, runs one bus transaction per load/store, extends load data.
// Latency: 0 cycles past the input register for ALU ops, >=3 for loads; mem_stall holds upstream while busy.
module mem_access #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [31:0]       alu_result_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_to_reg_in,
  input  logic              reg_write_in,
  input  logic [4:0]        write_reg_in,
  input  logic [31:0]       inst_in,
  mem_access_if.master      bus,
  output logic              mem_stall,
  output logic              adel,
  output logic              ades,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_reg,
  output logic              wb_we,
  output logic [31:0]       inst_out
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  typedef struct packed {
    logic [31:0]       alu_result;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] sdata;
    logic              rd;
    logic              wr;
    logic              to_reg;
    logic              we;
    logic [4:0]        dst;
    logic [31:0]       inst;
  } ex_op_t;

  // Non-memory ops decode to size 0 so the idle bus outputs sit at zero.
  function automatic logic [1:0] size_of(input logic [5:0] opc, input logic rd, input logic wr);
    case (opc)
      OP_LB, OP_LBU, OP_SB: size_of = 2'd0;
      OP_LH, OP_LHU, OP_SH: size_of = 2'd1;
      OP_LW, OP_SW:         size_of = 2'd2;
      default:              size_of = (rd || wr) ? 2'd2 : 2'd0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    misaligned = ((sz == 2'd1) && a[0]) || ((sz == 2'd2) && (a != 2'b00));
  endfunction

  state_t            state;
  ex_op_t            op_q;
  ex_op_t            op_in;
  logic              req_q;
  logic [DATA_W-1:0] rdata_q;
  logic              capture;
  logic              go_in;
  logic [1:0]        size;
  logic              mis;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_ext;

  always_comb begin
    op_in = '{alu_result: alu_result_in, addr: mem_addr_in, sdata: store_data_in,
              rd: mem_read_in, wr: mem_write_in, to_reg: mem_to_reg_in,
              we: reg_write_in, dst: write_reg_in, inst: inst_in};
  end

  assign mem_stall = (state == REQ) || ((state == WAIT) && !bus.data_data_ok);
  assign capture   = !stall && !mem_stall;
  assign go_in     = (mem_read_in || mem_write_in) &&
                     !misaligned(size_of(inst_in[31:26], mem_read_in, mem_write_in), mem_addr_in[1:0]);

  // A new op can be captured on the data_ok edge, so WAIT may chain straight into REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      req_q   <= 1'b0;
      op_q    <= '0;
      rdata_q <= '0;
    end else begin
      if (capture) begin
        op_q <= op_in;
      end
      case (state)
        IDLE: begin
          if (capture && go_in) begin
            state <= REQ;
            req_q <= 1'b1;
          end
        end
        REQ: begin
          if (bus.data_addr_ok) begin
            state <= WAIT;
            req_q <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.data_data_ok) begin
            rdata_q <= bus.data_rdata;
            if (capture && go_in) begin
              state <= REQ;
              req_q <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign size = size_of(op_q.inst[31:26], op_q.rd, op_q.wr);
  assign mis  = misaligned(size, op_q.addr[1:0]);
  assign adel = op_q.rd && mis;
  assign ades = op_q.wr && mis;

  assign bus.data_req  = req_q;
  assign bus.data_wr   = op_q.wr;
  assign bus.data_size = size;
  assign bus.data_addr = op_q.addr;

  always_comb begin
    case (size)
      2'd0:    bus.data_wdata = {4{op_q.sdata[7:0]}};
      2'd1:    bus.data_wdata = {2{op_q.sdata[15:0]}};
      default: bus.data_wdata = op_q.sdata;
    endcase
  end

  assign ld_byte = rdata_q[{op_q.addr[1:0], 3'b000} +: 8];
  assign ld_half = rdata_q[{op_q.addr[1], 4'b0000} +: 16];

  always_comb begin
    case (op_q.inst[31:26])
      OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_ext = {24'h0, ld_byte};
      OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_ext = {16'h0, ld_half};
      default: ld_ext = rdata_q;
    endcase
  end

  assign wb_data  = op_q.to_reg ? ld_ext : op_q.alu_result;
  assign wb_reg   = op_q.dst;
  assign wb_we    = op_q.we && !mem_stall && !adel && !ades;
  assign inst_out = op_q.inst;

endmodule

// File: tb/tb_mem_access.sv
// Randomized and directed bench for mem_access against a byte-lane reference model.
module tb_mem_access;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_ALU = 6'b000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] alu_result_in, mem_addr_in, store_data_in, inst_in;
  logic        mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in;
  logic [4:0]  write_reg_in;
  logic        mem_stall, adel, ades, wb_we;
  logic [31:0] wb_data, inst_out;
  logic [4:0]  wb_reg;

  int total = 0;
  int bad   = 0;

  mem_access_if bus ();

  mem_access dut (
    .clk(clk), .rst(rst), .stall(stall),
    .alu_result_in(alu_result_in), .mem_addr_in(mem_addr_in), .store_data_in(store_data_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
    .reg_write_in(reg_write_in), .write_reg_in(write_reg_in), .inst_in(inst_in),
    .bus(bus),
    .mem_stall(mem_stall), .adel(adel), .ades(ades),
    .wb_data(wb_data), .wb_reg(wb_reg), .wb_we(wb_we), .inst_out(inst_out)
  );

  always #5 clk = ~clk;

  function automatic bit is_load(input logic [5:0] opc);
    return (opc == OP_LB) || (opc == OP_LBU) || (opc == OP_LH) || (opc == OP_LHU) || (opc == OP_LW);
  endfunction

  function automatic bit is_store(input logic [5:0] opc);
    return (opc == OP_SB) || (opc == OP_SH) || (opc == OP_SW);
  endfunction

  function automatic int op_bytes(input logic [5:0] opc);
    if (opc == OP_LB || opc == OP_LBU || opc == OP_SB) return 1;
    if (opc == OP_LH || opc == OP_LHU || opc == OP_SH) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] opc, input logic [31:0] addr,
                                             input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (addr % 4))) & 32'hFF;
    h = (w >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
    if (opc == OP_LB)  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
    if (opc == OP_LBU) return b;
    if (opc == OP_LH)  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
    if (opc == OP_LHU) return h;
    return w;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [5:0] opc, input logic [31:0] d);
    if (op_bytes(opc) == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (op_bytes(opc) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] opc, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [31:0] alu, input logic [4:0] dst, input logic we);
    mem_read_in   = is_load(opc);
    mem_write_in  = is_store(opc);
    mem_to_reg_in = is_load(opc);
    reg_write_in  = we;
    write_reg_in  = dst;
    mem_addr_in   = addr;
    store_data_in = sdata;
    alu_result_in = alu;
    inst_in       = {opc, 26'($urandom)};
  endtask

  // Present one op, capture it, then keep the register held while the bus is serviced.
  task automatic mem_txn(input string tag, input logic [5:0] opc, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] alu, input logic [31:0] rword,
                         input logic [4:0] dst, input logic we, input int a_dly, input int d_dly,
                         input bit noise);
    logic [31:0] exp_inst;
    logic [1:0]  exp_size;
    bit          rd, wr, aligned;
    int          stalls;
    rd = is_load(opc);
    wr = is_store(opc);
    exp_size = (op_bytes(opc) == 1) ? 2'd0 : (op_bytes(opc) == 2) ? 2'd1 : 2'd2;
    aligned = (addr % 32'(op_bytes(opc))) == 0;
    drive(opc, addr, sdata, alu, dst, we);
    exp_inst = inst_in;
    stall = 1'b0;
    step();
    stall = 1'b1;

    if (!rd && !wr) begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if ({bus.data_req, mem_stall} !== 2'b00) begin
          bad++; $display("FAIL %s alu req/stall: got %b want 00", tag, {bus.data_req, mem_stall});
        end
        step();
      end
      total++;
      if ({wb_data, wb_reg, wb_we, inst_out} !== {alu, dst, we, exp_inst}) begin
        bad++; $display("FAIL %s alu wb: got %h/%0d/%b want %h/%0d/%b", tag, wb_data, wb_reg, wb_we, alu, dst, we);
      end
      return;
    end

    if (!aligned) begin
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({adel, ades, bus.data_req, mem_stall, wb_we} !== {rd, wr, 3'b000}) begin
          bad++; $display("FAIL %s misalign adel/ades/req/stall/we: got %b want %b", tag,
                          {adel, ades, bus.data_req, mem_stall, wb_we}, {rd, wr, 3'b000});
        end
        step();
      end
      return;
    end

    total++;
    if ({adel, ades} !== 2'b00) begin
      bad++; $display("FAIL %s aligned adel/ades: got %b want 00", tag, {adel, ades});
    end
    stalls = 0;
    for (int i = 0; i <= a_dly; i++) begin
      total++;
      if ({bus.data_req, bus.data_wr, bus.data_size, bus.data_addr, bus.data_wdata} !==
          {1'b1, wr, exp_size, addr, (wr ? model_wdata(opc, sdata) : bus.data_wdata)}) begin
        bad++; $display("FAIL %s req phase: got req=%b wr=%b sz=%0d a=%h wd=%h want wr=%b sz=%0d a=%h wd=%h",
                        tag, bus.data_req, bus.data_wr, bus.data_size, bus.data_addr, bus.data_wdata,
                        wr, exp_size, addr, model_wdata(opc, sdata));
      end
      bus.data_data_ok = noise;
      bus.data_rdata   = $urandom;
      bus.data_addr_ok = (i == a_dly);
      #1;
      if (mem_stall) stalls++;
      step();
      bus.data_data_ok = 1'b0;
    end
    bus.data_addr_ok = 1'b0;
    for (int j = 0; j <= d_dly; j++) begin
      total++;
      if (bus.data_req !== 1'b0) begin
        bad++; $display("FAIL %s wait req: got %b want 0", tag, bus.data_req);
      end
      bus.data_data_ok = (j == d_dly);
      bus.data_rdata   = (j == d_dly) ? rword : $urandom;
      #1;
      if (mem_stall) stalls++;
      step();
    end
    bus.data_data_ok = 1'b0;
    total++;
    if (stalls != a_dly + 1 + d_dly) begin
      bad++; $display("FAIL %s stall cycles: got %0d want %0d", tag, stalls, a_dly + 1 + d_dly);
    end
    total++;
    if ({wb_data, wb_reg, wb_we, mem_stall, bus.data_req} !==
        {(rd ? model_load(opc, addr, rword) : alu), dst, we, 2'b00}) begin
      bad++; $display("FAIL %s writeback: got %h/%0d/%b stall=%b req=%b want %h/%0d/%b", tag, wb_data,
                      wb_reg, wb_we, mem_stall, bus.data_req, (rd ? model_load(opc, addr, rword) : alu), dst, we);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    total++;
    if ({bus.data_req, bus.data_wr, bus.data_size, bus.data_addr, bus.data_wdata} !== '0) begin
      bad++; $display("FAIL reset bus: got req=%b wr=%b sz=%0d a=%h wd=%h want all 0",
                      bus.data_req, bus.data_wr, bus.data_size, bus.data_addr, bus.data_wdata);
    end
    total++;
    if ({mem_stall, adel, ades, wb_we} !== 4'b0000) begin
      bad++; $display("FAIL reset flags: got %b want 0000", {mem_stall, adel, ades, wb_we});
    end
    total++;
    if ({wb_data, wb_reg, inst_out} !== '0) begin
      bad++; $display("FAIL reset wb: got %h/%0d/%h want 0", wb_data, wb_reg, inst_out);
    end
  endtask

  task automatic test_alu();
    mem_txn("alu_addu", OP_ALU, 32'h0, 32'h0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 0, 0, 1'b0);
  endtask

  task automatic test_lw();
    mem_txn("lw_1000", OP_LW, 32'h1000, 32'h0, 32'h5555, 32'hDEAD_BEEF, 5'd8, 1'b1, 2, 1, 1'b0);
  endtask

  task automatic test_byte_loads();
    mem_txn("lb_1003", OP_LB, 32'h1003, 32'h0, 32'h0, 32'h80FF_FF7F, 5'd9, 1'b1, 0, 0, 1'b0);
    mem_txn("lbu_1003", OP_LBU, 32'h1003, 32'h0, 32'h0, 32'h80FF_FF7F, 5'd10, 1'b1, 1, 0, 1'b1);
    mem_txn("lh_2002", OP_LH, 32'h2002, 32'h0, 32'h0, 32'h9ABC_1234, 5'd11, 1'b1, 0, 2, 1'b0);
    mem_txn("lhu_2002", OP_LHU, 32'h2002, 32'h0, 32'h0, 32'h9ABC_1234, 5'd12, 1'b1, 1, 1, 1'b0);
  endtask

  task automatic test_store();
    mem_txn("sh_2002", OP_SH, 32'h2002, 32'h1234_ABCD, 32'h77, 32'h0, 5'd0, 1'b0, 3, 0, 1'b1);
    mem_txn("sb_3001", OP_SB, 32'h3001, 32'h1234_ABCD, 32'h77, 32'h0, 5'd0, 1'b0, 0, 1, 1'b0);
  endtask

  task automatic test_misaligned();
    mem_txn("lw_1002", OP_LW, 32'h1002, 32'h0, 32'h0, 32'h0, 5'd3, 1'b1, 0, 0, 1'b0);
    mem_txn("sw_1001", OP_SW, 32'h1001, 32'hCAFE, 32'h0, 32'h0, 5'd0, 1'b0, 0, 0, 1'b0);
    mem_txn("lhu_odd", OP_LHU, 32'h4001, 32'h0, 32'h0, 32'h0, 5'd4, 1'b1, 0, 0, 1'b0);
  endtask

  task automatic test_reset_abort();
    drive(OP_LW, 32'h3000, 32'h0, 32'h0, 5'd7, 1'b1);
    stall = 1'b0;
    step();
    stall = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({bus.data_req, mem_stall} !== 2'b00) begin
      bad++; $display("FAIL reset_in_req: got req/stall=%b want 00", {bus.data_req, mem_stall});
    end
    drive(OP_LW, 32'h3004, 32'h0, 32'h0, 5'd7, 1'b1);
    stall = 1'b0;
    step();
    stall = 1'b1;
    bus.data_addr_ok = 1'b1;
    step();
    bus.data_addr_ok = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h1357_9BDF;
    #1;
    total++;
    if ({bus.data_req, mem_stall, wb_we, wb_data} !== {3'b000, 32'h0}) begin
      bad++; $display("FAIL reset_in_wait: got req=%b stall=%b we=%b wb=%h want 0", bus.data_req,
                      mem_stall, wb_we, wb_data);
    end
    step();
    bus.data_data_ok = 1'b0;
    total++;
    if ({bus.data_req, mem_stall, wb_we, wb_data, inst_out} !== '0) begin
      bad++; $display("FAIL late_data_ok: got req=%b stall=%b we=%b wb=%h inst=%h want 0",
                      bus.data_req, mem_stall, wb_we, wb_data, inst_out);
    end
  endtask

  task automatic test_back_to_back();
    drive(OP_LW, 32'h5000, 32'h0, 32'h0, 5'd13, 1'b1);
    stall = 1'b0;
    step();
    stall = 1'b1;
    bus.data_addr_ok = 1'b1;
    step();
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h0BAD_F00D;
    drive(OP_LBU, 32'h6002, 32'h0, 32'h0, 5'd14, 1'b1);
    stall = 1'b0;
    step();
    stall = 1'b1;
    bus.data_data_ok = 1'b0;
    total++;
    if ({bus.data_req, mem_stall, bus.data_addr, inst_out} !== {2'b11, 32'h6002, inst_in}) begin
      bad++; $display("FAIL b2b chain: got req=%b stall=%b a=%h want req=1 stall=1 a=6002",
                      bus.data_req, mem_stall, bus.data_addr);
    end
    bus.data_addr_ok = 1'b1;
    step();
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h00C3_0000;
    step();
    bus.data_data_ok = 1'b0;
    total++;
    if ({wb_data, wb_reg, wb_we} !== {32'h0000_00C3, 5'd14, 1'b1}) begin
      bad++; $display("FAIL b2b second: got %h/%0d/%b want 000000c3/14/1", wb_data, wb_reg, wb_we);
    end
  endtask

  task automatic test_random();
    logic [5:0]  ops [9] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, OP_ALU};
    logic [5:0]  opc;
    logic [31:0] addr;
    for (int n = 0; n < 40; n++) begin
      opc  = ops[$urandom_range(0, 8)];
      addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) addr = addr | 32'($urandom_range(1, 3));
      else if (op_bytes(opc) < 4) addr = addr | 32'($urandom_range(0, 3) & (4 - op_bytes(opc)));
      mem_txn($sformatf("rand%0d", n), opc, addr, $urandom, $urandom, $urandom, 5'($urandom),
              is_store(opc) ? 1'b0 : 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b1;
    drive(OP_ALU, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 32'h0;
    test_reset();
    test_alu();
    test_lw();
    test_byte_loads();
    test_store();
    test_misaligned();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage of the cqu_mips five-stage pipeline. It is the receiving end of the execute stage's memory interface.
- It registers the execute-stage outputs: ALU result, memory address, read/write flags, write-back controls and instruction word.
- It decodes the load/store width from the instruction opcode and runs a request/response handshake with the data SRAM bus.
- It extends load data and hands the write-back value to the writeback stage. It raises mem_stall while a transaction is outstanding.

Parameters:
- ADDR_W, 32, data bus address width.
- DATA_W, 32, data bus word width; fixed at 32, byte lanes are 4.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  global pipeline stall from hazard unit; holds the input register.
- alu_result_in  in  32  ALU result from execute.
- mem_addr_in  in  32  effective address (src1 + imm) from execute.
- store_data_in  in  32  rt value to store.
- mem_read_in  in  1  load operation.
- mem_write_in  in  1  store operation.
- mem_to_reg_in  in  1  write-back selects load data.
- reg_write_in  in  1  register write enable.
- write_reg_in  in  5  destination register.
- inst_in  in  32  instruction word; bits [31:26] are the opcode.
- data_req  out  1  bus request valid.
- data_wr  out  1  1 = write, 0 = read.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr  out  32  byte address.
- data_wdata  out  32  lane-replicated store data.
- data_addr_ok  in  1  request accepted.
- data_rdata  in  32  read word, valid with data_data_ok.
- data_data_ok  in  1  response.
- mem_stall  out  1  transaction pending; stalls upstream stages.
- adel  out  1  misaligned load (registered op).
- ades  out  1  misaligned store (registered op).
- wb_data  out  32  write-back value.
- wb_reg  out  5  write-back register.
- wb_we  out  1  write-back enable.
- inst_out  out  32  registered instruction.

Behaviour:
- Input register: captures all *_in on posedge when !stall && !mem_stall; otherwise holds. Reset clears all fields to 0, so inst = 0 (NOP) and all enables are 0.
- Width decode from the registered opcode:
  - LB 100000, LBU 100100: size 0.
  - LH 100001, LHU 100101, SH 101001: size 1.
  - LW 100011, SW 101011: size 2.
  - SB 101000: size 0.
  - Any other opcode with mem_read/mem_write set is treated as word.
- Alignment: size 1 requires addr[0] = 0; size 2 requires addr[1:0] = 0.
  - Misaligned load sets adel=1; misaligned store sets ades=1. Both are combinational from the registered op.
  - A misaligned op issues no bus request and wb_we is forced to 0.
- FSM states IDLE, REQ, WAIT:
  - IDLE -> REQ: on the capture edge whose captured op has (mem_read|mem_write) and is aligned.
  - REQ: data_req=1 and data_addr/size/wr/wdata are held stable. On data_addr_ok go to WAIT.
  - WAIT: data_req=0. On data_data_ok, capture data_rdata into rdata_reg and go to IDLE.
  - The bus never returns data_data_ok in the same cycle as data_addr_ok. data_data_ok in IDLE or REQ is ignored.
- mem_stall = (state==REQ) || (state==WAIT && !data_data_ok). It drops combinationally in the data_ok cycle, so the next op is captured on that edge.
- Store data: SB uses {4{wdata[7:0]}}; SH uses {2{wdata[15:0]}}; SW uses the word unchanged. data_addr is the full byte address.
- Load extract (little-endian):
  - Byte = rdata_reg[8*addr[1:0] +: 8]; half = rdata_reg[16*addr[1] +: 16].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- wb_data = mem_to_reg ? extended load : alu_result. wb_reg = registered write_reg. wb_we = reg_write && !mem_stall && !adel && !ades.
- Latency:
  - Non-memory op: zero cycles beyond the input register.
  - Load: ≥3 cycles (capture, REQ, WAIT). Data appears in wb_data from the cycle after data_ok.
- Reset output values:
  - All outputs 0 and state=IDLE.
  - Reset during REQ or WAIT aborts the transaction: data_req=0 in the next cycle, and a late data_data_ok is ignored.
- Holding behaviour: stall asserted while busy has no effect on the FSM. The transaction completes and the register holds until both stall and mem_stall are low.

Test Plan:
- ALU op (addu, alu_result_in=0x0000_1234, reg_write=1, write_reg=5) -> one cycle after capture: wb_data=0x1234, wb_reg=5, wb_we=1, data_req never asserted.
- LW at 0x1000; addr_ok 2 cycles after req; data_ok=1 with rdata=0xDEAD_BEEF 1 cycle later -> mem_stall high 4 cycles; wb_data=0xDEADBEEF next cycle, wb_we=1.
- LB at 0x1003 with rdata=0x80FF_FF7F -> wb_data=0xFFFF_FF80; LBU at the same address -> 0x0000_0080.
- SH at 0x2002 with store_data=0x1234_ABCD -> data_wr=1, data_size=1, data_addr=0x2002, data_wdata=0xABCD_ABCD held until addr_ok.
- LW at 0x1002 -> adel=1, data_req=0, wb_we=0, mem_stall=0.
- Reset pulse in WAIT, followed by data_data_ok -> state IDLE, data_req=0, wb_we=0, rdata not updated.
